// File: rtl/rand_range_sampler_if.sv
// rand_range_sampler_if
//   Request/response channel of the random range sampler.
//   Request side : range (modulus N), req, req_ready.
//   Response side: sample, sample_valid, sample_ready, tries, biased.
//   master = requester/consumer, slave = the sampler.
interface rand_range_sampler_if #(
    parameter int MAX_TRIES = 16
);
    localparam int TW = $clog2(MAX_TRIES + 1);

    logic [7:0]    range;
    logic          req;
    logic          req_ready;
    logic [7:0]    sample;
    logic          sample_valid;
    logic          sample_ready;
    logic [TW-1:0] tries;
    logic          biased;

    modport master (
        output range, req, sample_ready,
        input  req_ready, sample, sample_valid, tries, biased
    );

    modport slave (
        input  range, req, sample_ready,
        output req_ready, sample, sample_valid, tries, biased
    );
endinterface

// File: rtl/rand_range_sampler.sv
// rand_range_sampler
//   Turns a free-running 8-bit LFSR byte stream into unbiased values in
//   [0, N-1] by mask-and-reject sampling, with a bounded number of retries
//   followed by a biased fallback. A repetition-count health test watches
//   the raw stream and raises a sticky stuck_err.
// Ports:
//   clk       : clock, all logic on posedge
//   rst       : synchronous active-high reset
//   random    : raw LFSR byte, new value every cycle
//   bus       : request/response channel (slave modport)
//   range_err : one-cycle pulse, request made with range == 0
//   stuck_err : sticky health-test failure
module rand_range_sampler #(
    parameter int MAX_TRIES = 16,
    parameter int REP_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           random,
    rand_range_sampler_if.slave  bus,
    output logic                 range_err,
    output logic                 stuck_err
);
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int RW = $clog2(REP_LIMIT);
    localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);
    localparam logic [TW-1:0] ALL_TRIES = TW'(MAX_TRIES);
    localparam logic [RW-1:0] REP_MAX = RW'(REP_LIMIT - 1);

    typedef enum logic [1:0] {IDLE, DRAW, HOLD} state_t;

    state_t        r_state;
    logic [7:0]    r_n;
    logic [7:0]    r_mask;
    logic [TW-1:0] r_try;
    logic          r_skip;
    logic [7:0]    r_sample;
    logic [TW-1:0] r_tries;
    logic          r_biased;
    logic          r_range_err;
    logic [7:0]    r_prev;
    logic [RW-1:0] r_rep;
    logic          r_stuck_err;

    logic [7:0]    w_nm1;
    logic [7:0]    w_s1;
    logic [7:0]    w_s2;
    logic [7:0]    w_mask;
    logic [7:0]    w_cand;
    logic          w_req_ready;

    // Smallest all-ones mask covering N-1, so a masked byte lies in
    // [0, 2N-1] and acceptance probability is above one half.
    // NOTE: always_comb assigns every variable on every path so no latch
    // is inferred; here each term is a straight assignment.
    always_comb begin
        w_nm1  = bus.range - 8'd1;
        w_s1   = w_nm1 | (w_nm1 >> 1);
        w_s2   = w_s1 | (w_s1 >> 2);
        w_mask = w_s2 | (w_s2 >> 4);
        w_cand = random & r_mask;
    end

    assign w_req_ready = (r_state == IDLE) && !r_stuck_err;

    // Repetition-count health test, independent of the sampler state.
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev      <= 8'd0;
            r_rep       <= '0;
            r_stuck_err <= 1'b0;
        end else begin
            r_prev <= random;
            if (random != r_prev) begin
                r_rep <= '0;
            end else if (r_rep != REP_MAX) begin
                r_rep <= r_rep + 1'b1;
                // REP_LIMIT identical bytes seen once the count hits its top
                if (r_rep == REP_MAX - 1'b1) begin
                    r_stuck_err <= 1'b1;
                end
            end
        end
    end

    // Sampler FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_n         <= 8'd0;
            r_mask      <= 8'd0;
            r_try       <= '0;
            r_skip      <= 1'b0;
            r_sample    <= 8'd0;
            r_tries     <= '0;
            r_biased    <= 1'b0;
            r_range_err <= 1'b0;
        end else begin
            r_range_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.req && w_req_ready) begin
                        if (bus.range == 8'd0) begin
                            r_range_err <= 1'b1;
                        end else begin
                            r_n     <= bus.range;
                            r_mask  <= w_mask;
                            r_try   <= '0;
                            r_skip  <= 1'b1;
                            r_state <= DRAW;
                        end
                    end
                end
                DRAW: begin
                    // The byte that shares the acceptance cycle is let
                    // through; examination starts with the following one.
                    if (r_skip) begin
                        r_skip <= 1'b0;
                    end else if (w_cand < r_n) begin
                        r_sample <= w_cand;
                        r_tries  <= r_try;
                        r_biased <= 1'b0;
                        r_state  <= HOLD;
                    end else if (r_try == LAST_TRY) begin
                        // mask <= 2N-1, so a rejected candidate minus N is < N
                        r_sample <= w_cand - r_n;
                        r_tries  <= ALL_TRIES;
                        r_biased <= 1'b1;
                        r_state  <= HOLD;
                    end else begin
                        r_try <= r_try + 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.sample_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.sample       = r_sample;
    assign bus.sample_valid = (r_state == HOLD);
    assign bus.tries        = r_tries;
    assign bus.biased       = r_biased;
    assign range_err        = r_range_err;
    assign stuck_err        = r_stuck_err;
endmodule

// File: doc/rand_range_sampler.md
Name: rand_range_sampler

Overview:
Downstream consumer of the 8-bit free-running LFSR byte stream. On request, it turns raw random bytes into an unbiased value in [0, range-1] using mask-and-reject sampling, and returns it over a valid/ready handshake. It also runs a repetition-count health test on the incoming stream and flags a stuck generator.

Parameters:
MAX_TRIES, 16, consecutive rejections allowed before the fallback (biased) result is delivered; must be at least 1.
REP_LIMIT, 8, number of identical consecutive input bytes that trips stuck_err; must be at least 2.

Ports:
clk  input  1  single clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
random  input  8  LFSR byte; a new value every cycle.
range  input  8  modulus N; sampled only on request acceptance.
req  input  1  request for one sample.
req_ready  output  1  block can accept a request.
sample  output  8  result; always less than the latched N.
sample_valid  output  1  sample, tries and biased are valid.
sample_ready  input  1  consumer accepts the sample.
tries  output  $clog2(MAX_TRIES+1) (5 at default)  rejected bytes before the result.
biased  output  1  result came from the fallback path.
range_err  output  1  one-cycle pulse: request made with range equal to 0.
stuck_err  output  1  sticky health-test failure.

Behaviour:
- Reset (rst high at a posedge): FSM goes to IDLE.
  - sample=0, sample_valid=0, tries=0, biased=0, range_err=0, stuck_err=0.
  - Repetition counter cleared, previous-byte register cleared.
  - Reset mid-draw or mid-hold aborts the operation; sample_valid is low in the cycle after the reset edge.
- FSM states: IDLE, DRAW, HOLD.
- IDLE:
  - req_ready = !stuck_err.
  - On req && req_ready with range==0: range_err is high for exactly the next cycle; FSM stays in IDLE.
  - On req && req_ready with range!=0: latch N=range. Latch mask = smear(N-1), i.e. m |= m>>1, then m>>2, then m>>4. Clear the try counter. Go to DRAW.
- DRAW (req_ready=0): each cycle, candidate = random & mask.
  - candidate < N: sample<=candidate, tries<=try count, biased<=0, go to HOLD.
  - Otherwise increment the try count. If it reaches MAX_TRIES: sample<=candidate-N (always < N because mask <= 2N-1), tries<=MAX_TRIES, biased<=1, go to HOLD. Otherwise stay in DRAW.
  - Each input byte is examined at most once.
- Latency: request accepted at edge t; the first byte examined is the one present in cycle t+1. With first-byte acceptance, sample_valid is high from edge t+2.
- HOLD:
  - sample_valid=1; sample, tries and biased are stable; random is ignored.
  - On sample_ready: go to IDLE, so sample_valid=0 and req_ready=1 from the next cycle.
  - A new request cannot be accepted in the same cycle as the handshake.
- N=1 gives mask=0 and candidate=0, which is always accepted: sample=0, tries=0.
- N=255 gives mask=0xFF, so only byte 0xFF is rejected.
- Health test runs every cycle regardless of FSM state:
  - rep counts consecutive cycles where random equals the previous byte; it resets to 0 on any change.
  - When rep reaches REP_LIMIT-1 (REP_LIMIT identical bytes), stuck_err<=1. It stays high until rst.
  - While stuck_err=1, req_ready=0. A draw or hold already in progress still completes normally.

Test Plan:
- Normal draw: range=6 (mask 7); random 7,6,3 in the first three DRAW cycles -> sample=3, tries=2, biased=0; sample_valid high 4 cycles after acceptance.
- Unit range: range=1, any random -> sample=0, tries=0, sample_valid at edge t+2.
- Fallback: range=5 (mask 7); random alternating 6,7 starting with 6 -> after 16 rejections sample=2 (7-5), tries=16, biased=1.
- Backpressure: sample_ready held low 5 cycles while random keeps changing -> sample, tries and biased unchanged and sample_valid held; handshake on cycle 6 -> req_ready=1 on the next cycle.
- Zero range: req with range=0 -> range_err high for 1 cycle, FSM stays in IDLE, no sample_valid.
- Health and reset: random held at 0x5A for 8 cycles -> stuck_err rises and req_ready=0. rst asserted mid-DRAW of another run -> all outputs 0 next cycle and stuck_err cleared.
